// File: rtl/aes_pkg.sv
// aes_pkg
// Shared constants and helpers for the Rijndael state datapath.
//   - Legal column counts (NB) for 128/192/256-bit blocks.
//   - shift_offset(nb, row): ShiftRows left-rotation amount for a row.
//   - byte_idx(row, col): byte number within a column-major state.
//   - SR_FWD / SR_INV: permutation mode select values.
//   - sr_state_e: occupancy state of the shift-rows output buffer,
//     encoded as {main valid, skid valid}.
package aes_pkg;

    localparam int NB_128 = 4;
    localparam int NB_192 = 6;
    localparam int NB_256 = 8;

    localparam logic SR_FWD = 1'b0;
    localparam logic SR_INV = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } sr_state_e;

    // The 256-bit block skips offset 2: rows 2 and 3 rotate by 3 and 4.
    function automatic int shift_offset(input int nb, input int row);
        if (nb == NB_256 && row >= 2) begin
            return row + 1;
        end
        return row;
    endfunction

    function automatic int byte_idx(input int row, input int col);
        return col * 4 + row;
    endfunction

endpackage

// File: rtl/rijndael_shift_perm.sv
// rijndael_shift_perm
// Pure combinational ShiftRows / InvShiftRows byte permutation.
// Ports:
//   data_in  [32*NB-1:0]  state block, byte 0 in the MSB byte, column-major
//   inv                   SR_FWD = ShiftRows, SR_INV = InvShiftRows
//   data_out [32*NB-1:0]  permuted block
module rijndael_shift_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] data_in,
    input  logic             inv,
    output logic [32*NB-1:0] data_out
);

    localparam int BLK_W = 32 * NB;

    if (NB != NB_128 && NB != NB_192 && NB != NB_256) begin : g_bad_nb
        $error("rijndael_shift_perm: NB must be 4, 6 or 8");
    end

    // Every output byte is a fixed 2:1 mux between its forward and inverse
    // source byte; all indices resolve at elaboration.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFS   = shift_offset(NB, r);
            localparam int DST   = byte_idx(r, c);
            localparam int SRC_F = byte_idx(r, (c + OFS) % NB);
            localparam int SRC_I = byte_idx(r, (c - OFS + NB) % NB);

            assign data_out[BLK_W-1-8*DST -: 8] =
                (inv == SR_INV) ? data_in[BLK_W-1-8*SRC_I -: 8]
                                : data_in[BLK_W-1-8*SRC_F -: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
// Registered ShiftRows / InvShiftRows stage with valid/ready handshake and
// a two-entry (main + skid) buffer so one block per cycle is sustained
// under backpressure.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready is a register output
//   in_data  [BLK_W]      state block
//   in_inv                0 = ShiftRows, 1 = InvShiftRows (sampled on accept)
//   in_tag   [TAG_W]      sideband carried with the block
//   out_valid / out_ready output handshake
//   out_data [BLK_W]      permuted block
//   out_tag  [TAG_W]      tag of the same block
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter  int NB    = 4,
    parameter  int TAG_W = 4,
    localparam int BLK_W = 32 * NB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_data,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    sr_state_e        state_q, state_d;
    logic [BLK_W-1:0] perm_data;
    logic [BLK_W-1:0] m_data_q, m_data_d;
    logic [BLK_W-1:0] s_data_q, s_data_d;
    logic [TAG_W-1:0] m_tag_q, m_tag_d;
    logic [TAG_W-1:0] s_tag_q, s_tag_d;
    logic             accept;
    logic             pop;

    rijndael_shift_perm #(.NB(NB)) u_perm (
        .data_in  (in_data),
        .inv      (in_inv),
        .data_out (perm_data)
    );

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_ONE;
            end
            ST_ONE: begin
                // An accept while stalled must park in the skid entry;
                // overwriting M would drop the block it holds.
                if (accept && !out_ready) begin
                    state_d = ST_FULL;
                end else if (!accept && pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Outputs: each flag is one bit of the state encoding, so both are
    // straight register outputs with no path from out_ready.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        in_ready  = (state_q != ST_FULL);
    end

    // Storage next-state.
    always_comb begin
        m_data_d = m_data_q;
        m_tag_d  = m_tag_q;
        s_data_d = s_data_q;
        s_tag_d  = s_tag_q;
        if (state_q == ST_FULL && pop) begin
            m_data_d = s_data_q;
            m_tag_d  = s_tag_q;
        end else if (accept && (state_q == ST_EMPTY || out_ready)) begin
            m_data_d = perm_data;
            m_tag_d  = in_tag;
        end else if (accept) begin
            s_data_d = perm_data;
            s_tag_d  = in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_q <= '0;
            m_tag_q  <= '0;
            s_data_q <= '0;
            s_tag_q  <= '0;
        end else begin
            m_data_q <= m_data_d;
            m_tag_q  <= m_tag_d;
            s_data_q <= s_data_d;
            s_tag_q  <= s_tag_d;
        end
    end

    assign out_data = m_data_q;
    assign out_tag  = m_tag_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: one instance each for NB = 4, 6 and 8.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic         a4_in_valid, a4_in_ready, a4_in_inv, a4_out_valid, a4_out_ready;
    logic [127:0] a4_in_data, a4_out_data;
    logic [3:0]   a4_in_tag, a4_out_tag;

    logic         a6_in_valid, a6_in_ready, a6_in_inv, a6_out_valid, a6_out_ready;
    logic [191:0] a6_in_data, a6_out_data;
    logic [3:0]   a6_in_tag, a6_out_tag;

    logic         a8_in_valid, a8_in_ready, a8_in_inv, a8_out_valid, a8_out_ready;
    logic [255:0] a8_in_data, a8_out_data;
    logic [3:0]   a8_in_tag, a8_out_tag;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(a4_in_valid), .in_ready(a4_in_ready), .in_data(a4_in_data),
        .in_inv(a4_in_inv), .in_tag(a4_in_tag),
        .out_valid(a4_out_valid), .out_ready(a4_out_ready),
        .out_data(a4_out_data), .out_tag(a4_out_tag)
    );

    shift_rows_pipe #(.NB(6), .TAG_W(4)) u6 (
        .clk(clk), .rst(rst),
        .in_valid(a6_in_valid), .in_ready(a6_in_ready), .in_data(a6_in_data),
        .in_inv(a6_in_inv), .in_tag(a6_in_tag),
        .out_valid(a6_out_valid), .out_ready(a6_out_ready),
        .out_data(a6_out_data), .out_tag(a6_out_tag)
    );

    shift_rows_pipe #(.NB(8), .TAG_W(4)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(a8_in_valid), .in_ready(a8_in_ready), .in_data(a8_in_data),
        .in_inv(a8_in_inv), .in_tag(a8_in_tag),
        .out_valid(a8_out_valid), .out_ready(a8_out_ready),
        .out_data(a8_out_data), .out_tag(a8_out_tag)
    );

    // Reference permutation, right-aligned in 256 bits.
    function automatic logic [255:0] perm_model(input int nb, input logic [255:0] d,
                                                input logic inv);
        logic [255:0] o;
        int w, ofs, sc;
        o = '0;
        w = 32 * nb;
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                ofs = (nb == 8 && r >= 2) ? r + 1 : r;
                sc  = inv ? (c - ofs + nb) % nb : (c + ofs) % nb;
                o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*sc+r) -: 8];
            end
        end
        return o;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a4_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", a4_out_valid);
        end
        checks++;
        if (a4_in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", a4_in_ready);
        end
        checks++;
        if (a4_out_data !== 128'd0) begin
            failures++; $display("FAIL reset_out_data got=%h exp=0", a4_out_data);
        end
        checks++;
        if (a4_out_tag !== 4'd0) begin
            failures++; $display("FAIL reset_out_tag got=%h exp=0", a4_out_tag);
        end
        checks++;
        if (a6_out_valid !== 1'b0 || a8_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid_6_8 got=%b%b exp=00", a6_out_valid, a8_out_valid);
        end
        rst = 1'b0;
    endtask

    // One NB=4 transaction with out_ready high; checks result then the bubble.
    task automatic run_nb4(input string name, input logic [127:0] din, input logic inv,
                           input logic [3:0] tag, input logic [127:0] exp);
        a4_out_ready = 1'b1;
        a4_in_valid  = 1'b1;
        a4_in_data   = din;
        a4_in_inv    = inv;
        a4_in_tag    = tag;
        @(posedge clk); #1;
        a4_in_valid = 1'b0;
        checks++;
        if (a4_out_valid !== 1'b1) begin
            failures++; $display("FAIL %s_valid got=%b exp=1", name, a4_out_valid);
        end
        checks++;
        if (a4_out_data !== exp) begin
            failures++; $display("FAIL %s_data got=%h exp=%h", name, a4_out_data, exp);
        end
        checks++;
        if (a4_out_tag !== tag) begin
            failures++; $display("FAIL %s_tag got=%h exp=%h", name, a4_out_tag, tag);
        end
        @(posedge clk); #1;
        checks++;
        if (a4_out_valid !== 1'b0) begin
            failures++; $display("FAIL %s_drain got=%b exp=0", name, a4_out_valid);
        end
    endtask

    task automatic test_fwd_nb4();
        run_nb4("fwd4", 128'hd42711ae_e0bf98f1_b8b45de5_1e415230, 1'b0, 4'h5,
                128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    endtask

    task automatic test_inv_nb4();
        run_nb4("inv4", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, 4'ha,
                128'hd42711ae_e0bf98f1_b8b45de5_1e415230);
    endtask

    task automatic test_nb8();
        logic [255:0] src, fwd;
        for (int k = 0; k < 32; k++) src[255-8*k -: 8] = 8'(k);
        a8_out_ready = 1'b1;
        a8_in_valid  = 1'b1;
        a8_in_data   = src;
        a8_in_inv    = 1'b0;
        a8_in_tag    = 4'h3;
        @(posedge clk); #1;
        a8_in_valid = 1'b0;
        fwd = a8_out_data;
        checks++;
        if (a8_out_valid !== 1'b1) begin
            failures++; $display("FAIL nb8_fwd_valid got=%b exp=1", a8_out_valid);
        end
        checks++;
        if (fwd[255:224] !== 32'h00050e13) begin
            failures++; $display("FAIL nb8_col0 got=%h exp=00050e13", fwd[255:224]);
        end
        checks++;
        if (fwd[31:0] !== 32'h1c010a0f) begin
            failures++; $display("FAIL nb8_col7 got=%h exp=1c010a0f", fwd[31:0]);
        end
        // Feed the forward result back through in inverse mode.
        a8_in_valid = 1'b1;
        a8_in_data  = fwd;
        a8_in_inv   = 1'b1;
        @(posedge clk); #1;
        a8_in_valid = 1'b0;
        checks++;
        if (a8_out_data !== src) begin
            failures++; $display("FAIL nb8_roundtrip got=%h exp=%h", a8_out_data, src);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure_nb6();
        logic [191:0] blk [10];
        logic         inv_a [10];
        logic [3:0]   tag_a [10];
        logic [191:0] exp_d [$];
        logic [3:0]   exp_t [$];
        logic [255:0] m;
        int  sent = 0, rcvd = 0, held = 0, cyc = 0, saw_full = 0;
        bit  acc, pp;
        for (int i = 0; i < 10; i++) begin
            blk[i]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            inv_a[i] = 1'($urandom_range(0, 1));
            tag_a[i] = 4'(i + 3);
        end
        while (rcvd < 10 && cyc < 400) begin
            a6_in_valid = (sent < 10);
            if (sent < 10) begin
                a6_in_data = blk[sent];
                a6_in_inv  = inv_a[sent];
                a6_in_tag  = tag_a[sent];
            end
            a6_out_ready = 1'($urandom_range(0, 1));
            if (held == 2) saw_full++;
            checks++;
            if (a6_in_ready !== (held < 2)) begin
                failures++;
                $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, a6_in_ready, held < 2);
            end
            checks++;
            if (a6_out_valid !== (held > 0)) begin
                failures++;
                $display("FAIL bp_out_valid cyc=%0d got=%b exp=%b", cyc, a6_out_valid, held > 0);
            end
            acc = a6_in_valid && a6_in_ready;
            pp  = a6_out_valid && a6_out_ready;
            if (pp && exp_d.size() > 0) begin
                checks++;
                if (a6_out_data !== exp_d[0] || a6_out_tag !== exp_t[0]) begin
                    failures++;
                    $display("FAIL bp_data n=%0d got=%h/%h exp=%h/%h", rcvd,
                             a6_out_data, a6_out_tag, exp_d[0], exp_t[0]);
                end
                void'(exp_d.pop_front());
                void'(exp_t.pop_front());
                rcvd++;
                held--;
            end
            if (acc) begin
                m = perm_model(6, {64'd0, blk[sent]}, inv_a[sent]);
                exp_d.push_back(m[191:0]);
                exp_t.push_back(tag_a[sent]);
                sent++;
                held++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        a6_in_valid  = 1'b0;
        a6_out_ready = 1'b1;
        checks++;
        if (rcvd != 10) begin
            failures++; $display("FAIL bp_count got=%0d exp=10", rcvd);
        end
        if (saw_full == 0) $display("note: backpressure run never filled both entries");
        @(posedge clk); #1;
    endtask

    task automatic test_reset_full();
        logic [255:0] m;
        a4_out_ready = 1'b0;
        a4_in_valid  = 1'b1;
        a4_in_inv    = 1'b0;
        a4_in_data   = 128'h00112233_44556677_8899aabb_ccddeeff;
        a4_in_tag    = 4'h1;
        @(posedge clk); #1;
        a4_in_data = 128'hffeeddcc_bbaa9988_77665544_33221100;
        a4_in_tag  = 4'h2;
        @(posedge clk); #1;
        a4_in_valid = 1'b0;
        m = perm_model(4, {128'd0, 128'h00112233_44556677_8899aabb_ccddeeff}, 1'b0);
        checks++;
        if (a4_in_ready !== 1'b0 || a4_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL full_flags got=%b%b exp=01", a4_in_ready, a4_out_valid);
        end
        checks++;
        if (a4_out_data !== m[127:0]) begin
            failures++; $display("FAIL full_head got=%h exp=%h", a4_out_data, m[127:0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a4_out_valid !== 1'b0 || a4_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstfull_flags got=%b%b exp=01", a4_out_valid, a4_in_ready);
        end
        checks++;
        if (a4_out_data !== 128'd0) begin
            failures++; $display("FAIL rstfull_data got=%h exp=0", a4_out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        a4_out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a4_out_valid !== 1'b0) begin
            failures++; $display("FAIL rstfull_stale got=%b exp=0", a4_out_valid);
        end
        run_nb4("after_rst", 128'hd42711ae_e0bf98f1_b8b45de5_1e415230, 1'b0, 4'hc,
                128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk [16];
        logic [255:0] m;
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 16; k++) blk[i][127-8*k -: 8] = 8'(16 * i + k);
        a4_out_ready = 1'b1;
        a4_in_valid  = 1'b1;
        a4_in_inv    = 1'b0;
        a4_in_data   = blk[0];
        a4_in_tag    = 4'd0;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk); #1;
            m = perm_model(4, {128'd0, blk[j]}, 1'b0);
            checks++;
            if (a4_out_valid !== 1'b1 || a4_in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_flags j=%0d got=%b%b exp=11", j, a4_out_valid, a4_in_ready);
            end
            checks++;
            if (a4_out_data !== m[127:0] || a4_out_tag !== 4'(j)) begin
                failures++;
                $display("FAIL b2b_data j=%0d got=%h/%h exp=%h/%h", j, a4_out_data,
                         a4_out_tag, m[127:0], 4'(j));
            end
            if (j < 15) begin
                a4_in_data = blk[j+1];
                a4_in_tag  = 4'(j + 1);
            end else begin
                a4_in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (a4_out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_end got=%b exp=0", a4_out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        a4_in_valid = 1'b0; a4_in_inv = 1'b0; a4_in_data = '0; a4_in_tag = '0; a4_out_ready = 1'b0;
        a6_in_valid = 1'b0; a6_in_inv = 1'b0; a6_in_data = '0; a6_in_tag = '0; a6_out_ready = 1'b0;
        a8_in_valid = 1'b0; a8_in_inv = 1'b0; a8_in_data = '0; a8_in_tag = '0; a8_out_ready = 1'b0;
        test_reset();
        test_fwd_nb4();
        test_inv_nb4();
        test_nb8();
        test_backpressure_nb6();
        test_reset_full();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
